// File: rtl/data_mem_responder_pkg.sv
// Shared CPU package: responder FSM states, default sizing
// and the address legality check used by the data memory.
package data_mem_responder_pkg;

   localparam int DEPTH_DEF   = 32;
   localparam int LATENCY_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   // Misaligned or beyond the last word.
   function automatic logic addr_err(
      input logic [31:0] a,
      input int          depth
   );
      return (a[1:0] != 2'b00) ||
             (a[31:2] >= 30'(depth));
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU-side request/response bus of the data memory responder.
// The CPU drives the master side, the responder the slave side.
interface data_mem_responder_if;

   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        busy_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ack_o, rdata_o, err_o, busy_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ack_o, rdata_o, err_o, busy_o
   );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Word storage: synchronous write port, registered read port.
// Only the read register is reset; the array keeps its contents.
module mem_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic          rclr,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Error acks clear the read register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (rclr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one request,
// acks it LATENCY cycles later, back-to-back from RESP.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input logic           clk_i,
   input logic           rst_i,
   data_mem_responder_if.slave bus
);

   localparam int AW     = $clog2(DEPTH);
   localparam bit DIRECT = (LATENCY == 1);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        we_q;

   logic        accept;
   logic        go_now;
   logic        go_wait;
   logic        enter_resp;
   logic        op_we;
   logic        op_err;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;

   assign accept  = bus.req_i &&
                    (state == IDLE || state == RESP);
   assign go_now  = accept && DIRECT;
   assign go_wait = (state == WAIT) && (cnt == 4'd1);

   // Single-cycle latency completes straight from the bus.
   assign op_we    = go_now ? bus.we_i    : we_q;
   assign op_addr  = go_now ? bus.addr_i  : addr_q;
   assign op_wdata = go_now ? bus.wdata_i : wdata_q;
   assign op_err   = addr_err(op_addr, DEPTH);

   assign enter_resp = !rst_i && (go_now || go_wait);

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk_i),
      .rst   (rst_i),
      .we    (enter_resp && op_we && !op_err),
      .waddr (op_addr[AW+1:2]),
      .wdata (op_wdata),
      .re    (enter_resp && !op_we && !op_err),
      .rclr  (enter_resp && op_err),
      .raddr (op_addr[AW+1:2]),
      .rdata (bus.rdata_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         bus.ack_o  <= 1'b0;
         bus.err_o  <= 1'b0;
         bus.busy_o <= 1'b0;
      end else begin
         bus.ack_o  <= 1'b0;
         bus.err_o  <= 1'b0;
         bus.busy_o <= 1'b0;
         unique case (state)
            IDLE, RESP: begin
               if (bus.req_i) begin
                  addr_q  <= bus.addr_i;
                  wdata_q <= bus.wdata_i;
                  we_q    <= bus.we_i;
                  if (DIRECT) begin
                     state     <= RESP;
                     bus.ack_o <= 1'b1;
                     bus.err_o <= op_err;
                  end else begin
                     state      <= WAIT;
                     cnt        <= 4'(LATENCY - 1);
                     bus.busy_o <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  cnt       <= '0;
                  bus.ack_o <= 1'b1;
                  bus.err_o <= op_err;
               end else begin
                  cnt        <= cnt - 4'd1;
                  bus.busy_o <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: LATENCY=4 and LATENCY=1 responders,
// expected acks queued on drive and popped on ack_o.
module tb_data_mem_responder;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] ref_m [2][32];
   logic [31:0] last [2];

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );

   data_mem_responder #(
      .DEPTH   (32),
      .LATENCY (1)
   ) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(
      input int          d,
      input bit          we,
      input logic [31:0] a,
      input logic [31:0] wd
   );
      exp_t     e;
      logic [4:0] ix;
      bit       bad;
      ix  = a[6:2];
      bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd32);
      e.cyc = cyc + ((d == 0) ? 4 : 1);
      if (bad) begin
         e.err   = 1'b1;
         e.rd    = '0;
         last[d] = '0;
      end else if (we) begin
         ref_m[d][ix] = wd;
         e.err = 1'b0;
         e.rd  = last[d];
      end else begin
         e.err   = 1'b0;
         e.rd    = ref_m[d][ix];
         last[d] = e.rd;
      end
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   task automatic drive(
      input int          d,
      input bit          we,
      input logic [31:0] a,
      input logic [31:0] wd
   );
      if (d == 0) begin
         bus_a.req_i   = 1'b1;
         bus_a.we_i    = we;
         bus_a.addr_i  = a;
         bus_a.wdata_i = wd;
      end else begin
         bus_b.req_i   = 1'b1;
         bus_b.we_i    = we;
         bus_b.addr_i  = a;
         bus_b.wdata_i = wd;
      end
      push(d, we, a, wd);
   endtask

   task automatic idle_a();
      bus_a.req_i   = 1'b0;
      bus_a.we_i    = 1'b0;
      bus_a.addr_i  = '0;
      bus_a.wdata_i = '0;
   endtask

   task automatic idle_b();
      bus_b.req_i   = 1'b0;
      bus_b.we_i    = 1'b0;
      bus_b.addr_i  = '0;
      bus_b.wdata_i = '0;
   endtask

   // Random request noise that must be ignored in WAIT.
   task automatic garble3();
      for (int i = 0; i < 3; i++) begin
         bus_a.req_i   = 1'($urandom_range(0, 1));
         bus_a.we_i    = 1'($urandom_range(0, 1));
         bus_a.addr_i  = $urandom & 32'h7C;
         bus_a.wdata_i = $urandom;
         step();
      end
   endtask

   task automatic mon(
      input int          d,
      input logic        ack,
      input logic        err,
      input logic [31:0] rd
   );
      exp_t e;
      int   n;
      n = (d == 0) ? qa.size() : qb.size();
      if (ack) begin
         if (n == 0) begin
            check((d == 0) ? "a_unexp_ack" : "b_unexp_ack",
                  32'(ack), 32'd0);
         end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check((d == 0) ? "a_ack_cyc" : "b_ack_cyc",
                  cyc, e.cyc);
            check((d == 0) ? "a_err" : "b_err",
                  32'(err), 32'(e.err));
            check((d == 0) ? "a_rdata" : "b_rdata",
                  rd, e.rd);
         end
      end else if (n != 0) begin
         e = (d == 0) ? qa[0] : qb[0];
         if (cyc >= e.cyc) begin
            check((d == 0) ? "a_ack_missing" : "b_ack_missing",
                  32'(ack), 32'd1);
            if (d == 0) void'(qa.pop_front());
            else        void'(qb.pop_front());
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      mon(0, bus_a.ack_o, bus_a.err_o, bus_a.rdata_o);
      mon(1, bus_b.ack_o, bus_b.err_o, bus_b.rdata_o);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      last[0] = '0;
      last[1] = '0;
      idle_b();
      // A request held during reset must not be taken.
      bus_a.req_i   = 1'b1;
      bus_a.we_i    = 1'b1;
      bus_a.addr_i  = 32'h10;
      bus_a.wdata_i = 32'hBAD0BAD0;
      rst = 1'b1;
      repeat (3) step();
      check("rst_ack",   32'(bus_a.ack_o),  0);
      check("rst_err",   32'(bus_a.err_o),  0);
      check("rst_busy",  32'(bus_a.busy_o), 0);
      check("rst_rdata", bus_a.rdata_o,     0);
      check("rst_b_ack", 32'(bus_b.ack_o),  0);
      check("rst_b_rd",  bus_b.rdata_o,     0);
      rst = 1'b0;
      idle_a();
      step();

      // Write with full busy/ack timing.
      drive(0, 1'b1, 32'h8, 32'hDEADBEEF);
      step();
      idle_a();
      for (int i = 0; i < 3; i++) begin
         check("t1_busy",  32'(bus_a.busy_o), 1);
         check("t1_noack", 32'(bus_a.ack_o),  0);
         step();
      end
      check("t1_ack",      32'(bus_a.ack_o),  1);
      check("t1_busy_ack", 32'(bus_a.busy_o), 0);
      step();

      // Read back and hold.
      drive(0, 1'b0, 32'h8, 32'h0);
      step();
      idle_a();
      repeat (4) step();
      check("t2_hold0", bus_a.rdata_o, 32'hDEADBEEF);
      step();
      check("t2_hold1", bus_a.rdata_o, 32'hDEADBEEF);

      // Back-to-back writes of words 0 and 1.
      drive(0, 1'b1, 32'h0, 32'h11111111);
      step();
      garble3();
      drive(0, 1'b1, 32'h4, 32'h22222222);
      step();
      garble3();
      idle_a();
      step();

      // Three back-to-back reads, noise in WAIT.
      drive(0, 1'b0, 32'h0, 32'h0);
      step();
      garble3();
      drive(0, 1'b0, 32'h4, 32'h0);
      step();
      garble3();
      drive(0, 1'b0, 32'h8, 32'h0);
      step();
      garble3();
      idle_a();
      step();

      // Error accesses; misaligned write must not land.
      drive(0, 1'b0, 32'h6, 32'h0);
      step();
      garble3();
      drive(0, 1'b0, 32'h80, 32'h0);
      step();
      garble3();
      drive(0, 1'b1, 32'hA, 32'h00000055);
      step();
      garble3();
      drive(0, 1'b0, 32'h8, 32'h0);
      step();
      garble3();
      idle_a();
      step();
      check("t4_rd8", bus_a.rdata_o, 32'hDEADBEEF);

      // Reset in the middle of a write.
      drive(0, 1'b1, 32'hC, 32'hCAFEF00D);
      step();
      garble3();
      idle_a();
      step();
      bus_a.req_i   = 1'b1;
      bus_a.we_i    = 1'b1;
      bus_a.addr_i  = 32'hC;
      bus_a.wdata_i = 32'h00001234;
      step();
      idle_a();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      last[0] = '0;
      last[1] = '0;
      check("t5_busy", 32'(bus_a.busy_o), 0);
      check("t5_ack",  32'(bus_a.ack_o),  0);
      repeat (5) step();
      drive(0, 1'b0, 32'hC, 32'h0);
      step();
      idle_a();
      repeat (4) step();
      check("t5_old", bus_a.rdata_o, 32'hCAFEF00D);

      // LATENCY=1: write then read, consecutive acks.
      drive(1, 1'b1, 32'h10, 32'hA5A50010);
      step();
      check("t6_busy0", 32'(bus_b.busy_o), 0);
      drive(1, 1'b0, 32'h10, 32'h0);
      step();
      idle_b();
      check("t6_busy1", 32'(bus_b.busy_o), 0);
      check("t6_rd",    bus_b.rdata_o, 32'hA5A50010);
      repeat (3) step();

      check("qa_empty", qa.size(), 0);
      check("qb_empty", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
